zet_mem8_bridge: RTL and testbench

- Wishbone slave that sits directly downstream of the CPU core's bus master (clk_i/rst_i, 20-bit byte address, 16-bit data, byte_o, stb_o/ack_i).
- Converts each 16-bit or byte access into one or two timed byte cycles on an asynchronous 8-bit SRAM/flash device.
- Returns a single-cycle ack to the core.
- Handles 8086-style unaligned word accesses natively, because every access is byte-serial.

---
 rtl/zet_mem8_bridge_pkg.sv | 22 ++
 rtl/zet_mem8_bridge_if.sv | 24 ++
 rtl/zet_mem8_phase.sv | 65 ++++++
 rtl/zet_mem8_bridge.sv | 148 ++++++++++++++
 tb/tb_zet_mem8_bridge.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/zet_mem8_bridge_pkg.sv
// Shared definitions for the 8-bit memory bridge.
//   state_e      : bridge FSM encoding (IDLE, LO byte phase, HI byte phase, ACK)
//   PHASE_CNT_W  : width of the per-phase strobe counter
//   adr_inc()    : next byte address, wrapping modulo 2^20
package zet_mem8_bridge_pkg;

  localparam int ADR_W       = 20;
  localparam int PHASE_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_ACK  = 2'd3
  } state_e;

  // The high byte of a word at 0xFFFFF lives at 0x00000.
  function automatic logic [ADR_W-1:0] adr_inc(input logic [ADR_W-1:0] a);
    return a + {{(ADR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/zet_mem8_bridge_if.sv
// Core-side Wishbone-style bus of the 8-bit memory bridge.
// Signal names are as seen from the bridge (slave):
//   adr_i  [19:0] byte address        dat_i [15:0] write data (low byte at adr_i)
//   dat_o  [15:0] read data           we_i  write, byte_i single-byte access
//   stb_i  request                    ack_o one-cycle completion pulse
interface zet_mem8_bridge_if;
  logic [19:0] adr_i;
  logic [15:0] dat_i;
  logic [15:0] dat_o;
  logic        we_i;
  logic        byte_i;
  logic        stb_i;
  logic        ack_o;

  modport master (
    output adr_i, dat_i, we_i, byte_i, stb_i,
    input  dat_o, ack_o
  );

  modport slave (
    input  adr_i, dat_i, we_i, byte_i, stb_i,
    output dat_o, ack_o
  );
endinterface

// File: rtl/zet_mem8_phase.sv
// Byte-phase timer for the 8-bit memory bridge.
// A phase is one setup cycle followed by WAIT_CYCLES+1 strobe cycles.
//   clk_i, rst_i : clock, synchronous active-low reset
//   start_i      : load the setup cycle of a new access (wins over run_i)
//   run_i        : advance while the bridge is inside a byte phase
//   setup_o      : current cycle is the setup cycle
//   strobe_o     : current cycle is a strobe cycle
//   last_o       : current cycle is the final strobe cycle of the phase
// WAIT_CYCLES legal range is 0..15.
module zet_mem8_phase
  import zet_mem8_bridge_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic run_i,
  output logic setup_o,
  output logic strobe_o,
  output logic last_o
);

  localparam logic [PHASE_CNT_W-1:0] LAST_CNT = PHASE_CNT_W'(WAIT_CYCLES);

  // The setup cycle is a separate flag so the counter only has to span the
  // strobe cycles (0..WAIT_CYCLES), which keeps it at 4 bits for WAIT=15.
  logic                   setup_q, setup_d;
  logic [PHASE_CNT_W-1:0] cnt_q, cnt_d;

  assign setup_o  = setup_q;
  assign strobe_o = ~setup_q;
  assign last_o   = ~setup_q && (cnt_q == LAST_CNT);

  always_comb begin
    setup_d = setup_q;
    cnt_d   = cnt_q;
    if (start_i) begin
      setup_d = 1'b1;
      cnt_d   = '0;
    end else if (run_i) begin
      if (setup_q) begin
        setup_d = 1'b0;
        cnt_d   = '0;
      end else if (last_o) begin
        // Wrap straight into the setup cycle of the following phase.
        setup_d = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      setup_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      setup_q <= setup_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/zet_mem8_bridge.sv
// 16-bit Wishbone slave to asynchronous 8-bit SRAM/flash bridge.
// Every access is split into one (byte) or two (word) timed byte phases,
// low byte first, so unaligned word accesses need no special handling.
//   clk_i, rst_i   : clock, synchronous active-low reset
//   bus            : core-side request/ack bus (slave modport)
//   mem_adr_o      : device byte address
//   mem_dat_o      : device write data
//   mem_dat_i      : device read data
//   mem_ce_n_o     : chip enable, low for the whole of each byte phase
//   mem_oe_n_o     : output enable, low on read strobe cycles
//   mem_we_n_o     : write enable, low on write strobe cycles
module zet_mem8_bridge
  import zet_mem8_bridge_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  zet_mem8_bridge_if.slave    bus,
  output logic [ADR_W-1:0]    mem_adr_o,
  output logic [7:0]          mem_dat_o,
  input  logic [7:0]          mem_dat_i,
  output logic                mem_ce_n_o,
  output logic                mem_oe_n_o,
  output logic                mem_we_n_o
);

  state_e           state_q, state_d;
  logic             we_q, we_d;
  logic             byte_q, byte_d;
  logic [7:0]       dat_hi_q, dat_hi_d;
  logic [15:0]      rd_q, rd_d;
  logic [ADR_W-1:0] mem_adr_q, mem_adr_d;
  logic [7:0]       mem_dat_q, mem_dat_d;

  logic in_phase;
  logic ph_start;
  logic ph_setup;
  logic ph_strobe;
  logic ph_last;
  logic strobe_act;

  assign in_phase = (state_q == ST_LO) || (state_q == ST_HI);
  // stb_i is only looked at in IDLE; this also restarts the phase timer.
  assign ph_start = (state_q == ST_IDLE) && bus.stb_i;

  zet_mem8_phase #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_phase (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (ph_start),
    .run_i    (in_phase),
    .setup_o  (ph_setup),
    .strobe_o (ph_strobe),
    .last_o   (ph_last)
  );

  // Device strobes only outside the setup cycle; the setup cycle between the
  // LO and HI strobes is what guarantees the we_n/oe_n gap between bytes.
  assign strobe_act = in_phase && ph_strobe && !ph_setup;

  // Controls decode straight from registered state, so a reset or ACK
  // releases them from the very next cycle.
  assign mem_ce_n_o = ~in_phase;
  assign mem_oe_n_o = ~(strobe_act && !we_q);
  assign mem_we_n_o = ~(strobe_act && we_q);
  assign mem_adr_o  = mem_adr_q;
  assign mem_dat_o  = mem_dat_q;

  assign bus.ack_o  = (state_q == ST_ACK);
  assign bus.dat_o  = rd_q;

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    byte_d    = byte_q;
    dat_hi_d  = dat_hi_q;
    rd_d      = rd_q;
    mem_adr_d = mem_adr_q;
    mem_dat_d = mem_dat_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.stb_i) begin
          state_d   = ST_LO;
          we_d      = bus.we_i;
          byte_d    = bus.byte_i;
          dat_hi_d  = bus.dat_i[15:8];
          mem_adr_d = bus.adr_i;
          mem_dat_d = bus.dat_i[7:0];
        end
      end

      ST_LO: begin
        if (ph_last) begin
          if (!we_q) begin
            rd_d[7:0] = mem_dat_i;
            if (byte_q) rd_d[15:8] = 8'h00;
          end
          if (byte_q) begin
            state_d = ST_ACK;
          end else begin
            state_d   = ST_HI;
            mem_adr_d = adr_inc(mem_adr_q);
            mem_dat_d = dat_hi_q;
          end
        end
      end

      ST_HI: begin
        if (ph_last) begin
          if (!we_q) rd_d[15:8] = mem_dat_i;
          state_d = ST_ACK;
        end
      end

      ST_ACK: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      byte_q    <= 1'b0;
      dat_hi_q  <= 8'h00;
      rd_q      <= 16'h0000;
      mem_adr_q <= '0;
      mem_dat_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      byte_q    <= byte_d;
      dat_hi_q  <= dat_hi_d;
      rd_q      <= rd_d;
      mem_adr_q <= mem_adr_d;
      mem_dat_q <= mem_dat_d;
    end
  end

endmodule

// File: tb/tb_zet_mem8_bridge.sv
// Bench for zet_mem8_bridge: three instances (WAIT_CYCLES 1, 0, 15) share
// the request inputs but have private strobes. Instance 0 talks to a
// writable device model; 1 and 2 read a fixed pattern ROM.
module tb_zet_mem8_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [19:0] adr;
  logic [15:0] dat;
  logic        we;
  logic        byt;
  logic [2:0]  stb_v;
  logic [2:0]  ack_v;
  logic [15:0] dato_v [3];
  logic [19:0] madr   [3];
  logic [7:0]  mdo    [3];
  logic [7:0]  mdi    [3];
  logic        ce_n   [3];
  logic        oe_n   [3];
  logic        we_n   [3];

  for (genvar g = 0; g < 3; g++) begin : gd
    zet_mem8_bridge_if bus ();
    assign bus.adr_i  = adr;
    assign bus.dat_i  = dat;
    assign bus.we_i   = we;
    assign bus.byte_i = byt;
    assign bus.stb_i  = stb_v[g];
    assign ack_v[g]   = bus.ack_o;
    assign dato_v[g]  = bus.dat_o;

    zet_mem8_bridge #(
      .WAIT_CYCLES (g == 0 ? 1 : (g == 1 ? 0 : 15))
    ) dut (
      .clk_i      (clk),
      .rst_i      (rst_n),
      .bus        (bus),
      .mem_adr_o  (madr[g]),
      .mem_dat_o  (mdo[g]),
      .mem_dat_i  (mdi[g]),
      .mem_ce_n_o (ce_n[g]),
      .mem_oe_n_o (oe_n[g]),
      .mem_we_n_o (we_n[g])
    );
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic int wait_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 0 : 15);
  endfunction

  // Background contents of every byte not explicitly written.
  function automatic logic [7:0] seed_b(input logic [19:0] a);
    return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'h3C;
  endfunction

  // Device model (instance 0) and reference memory (what the core expects).
  logic [7:0] dev  [bit [19:0]];
  logic [7:0] refm [bit [19:0]];

  function automatic logic [7:0] dev_rd(input logic [19:0] a);
    if (dev.exists(a)) return dev[a];
    return seed_b(a);
  endfunction

  function automatic logic [7:0] ref_rd(input int g, input logic [19:0] a);
    if (g != 0) return seed_b(a);
    if (refm.exists(a)) return refm[a];
    return seed_b(a);
  endfunction

  // Per-instance pin activity, counted once per cycle.
  int   ce_cnt [3];
  int   oe_cnt [3];
  int   we_cnt [3];
  int   both_cnt [3];
  int   oe_fall [3];
  int   we_fall [3];
  logic oe_p [3];
  logic we_p [3];
  logic [15:0] last_rd [3];

  always @(negedge clk) begin
    if (!ce_n[0] && !we_n[0]) dev[madr[0]] = mdo[0];
    for (int g = 0; g < 3; g++) begin
      mdi[g] = (!ce_n[g] && !oe_n[g]) ?
               ((g == 0) ? dev_rd(madr[g]) : seed_b(madr[g])) : 8'h00;
      if (!ce_n[g]) ce_cnt[g]++;
      if (!oe_n[g]) oe_cnt[g]++;
      if (!we_n[g]) we_cnt[g]++;
      if (!oe_n[g] && !we_n[g]) both_cnt[g]++;
      if (!oe_n[g] && oe_p[g]) oe_fall[g]++;
      if (!we_n[g] && we_p[g]) we_fall[g]++;
      oe_p[g] = oe_n[g];
      we_p[g] = we_n[g];
    end
  end

  // One access on instance g; stb drops at the negedge of cycle drop_at.
  task automatic txn(input int g, input bit w, input bit b, input logic [19:0] a,
                     input logic [15:0] d, input int drop_at);
    int wc, ph, exp_lat, lat, nack;
    logic [19:0] a_lo, a_hi, a1;
    logic [15:0] d_ack, exp_d;
    wc = wait_of(g); ph = b ? 1 : 2; exp_lat = ph * (wc + 2) + 1;
    lat = 0; nack = 0; a_lo = '0; a_hi = '0; d_ack = '0;
    a1 = a + 20'd1;
    @(negedge clk);
    adr = a; dat = d; we = w; byt = b; stb_v[g] = 1'b1;
    ce_cnt[g] = 0; oe_cnt[g] = 0; we_cnt[g] = 0;
    both_cnt[g] = 0; oe_fall[g] = 0; we_fall[g] = 0;
    @(posedge clk);
    for (int n = 1; n <= exp_lat + 2; n++) begin
      @(negedge clk);
      if (n == 1) begin
        adr = 20'($urandom); dat = 16'($urandom); we = ~w; byt = ~b;
        a_lo = madr[g];
      end
      if (n == drop_at) stb_v[g] = 1'b0;
      if (n == wc + 3) a_hi = madr[g];
      if (ack_v[g]) begin
        if (lat == 0) begin lat = n; d_ack = dato_v[g]; end
        else nack++;
      end
    end
    stb_v[g] = 1'b0;
    chk($sformatf("lat g%0d", g), lat, exp_lat);
    chk("extra_ack", nack, 0);
    chk("adr_lo", a_lo, a);
    if (!b) chk("adr_hi", a_hi, a1);
    chk("ce_cycles", ce_cnt[g], ph * (wc + 2));
    chk("oe_cycles", oe_cnt[g], w ? 0 : ph * (wc + 1));
    chk("we_cycles", we_cnt[g], w ? ph * (wc + 1) : 0);
    chk("oe_pulses", oe_fall[g], w ? 0 : ph);
    chk("we_pulses", we_fall[g], w ? ph : 0);
    chk("oe_we_overlap", both_cnt[g], 0);
    if (!w) begin
      exp_d = b ? {8'h00, ref_rd(g, a)} : {ref_rd(g, a1), ref_rd(g, a)};
      last_rd[g] = exp_d;
      chk("rdata", d_ack, exp_d);
    end else begin
      chk("wr_keeps_dat_o", d_ack, last_rd[g]);
      if (g == 0) begin
        refm[a] = d[7:0];
        if (!b) refm[a1] = d[15:8];
      end
    end
  endtask

  // Two word reads on instance 0 with stb held; the address changes after
  // the first sample so the second access must use the new one.
  task automatic b2b(input logic [19:0] a0, input logic [19:0] a2);
    int L, p1, p2, nack;
    logic [15:0] d2;
    L = 2 * (wait_of(0) + 2) + 1; p1 = 0; p2 = 0; nack = 0; d2 = '0;
    @(negedge clk);
    adr = a0; we = 1'b0; byt = 1'b0; stb_v[0] = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 2 * L + 3; n++) begin
      @(negedge clk);
      if (n == 1) adr = a2;
      if (ack_v[0]) begin
        nack++;
        if (p1 == 0) p1 = n;
        else if (p2 == 0) begin p2 = n; d2 = dato_v[0]; stb_v[0] = 1'b0; end
      end
    end
    stb_v[0] = 1'b0;
    chk("b2b_acks", nack, 2);
    chk("b2b_ack1", p1, L);
    chk("b2b_ack2", p2, 2 * L + 1);
    last_rd[0] = {ref_rd(0, a2 + 20'd1), ref_rd(0, a2)};
    chk("b2b_data2", d2, last_rd[0]);
  endtask

  initial begin
    int nack;
    logic [19:0] ra;
    rst_n = 1'b0; stb_v = '0; adr = '0; dat = '0; we = 1'b0; byt = 1'b0;
    for (int g = 0; g < 3; g++) begin
      oe_p[g] = 1'b1; we_p[g] = 1'b1; last_rd[g] = '0; mdi[g] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++)
      chk($sformatf("reset_state g%0d", g),
          {ack_v[g], dato_v[g], madr[g], mdo[g], ce_n[g], oe_n[g], we_n[g]},
          {1'b0, 16'h0000, 20'h00000, 8'h00, 3'b111});
    rst_n = 1'b1;

    dev[20'h12345] = 8'hAB; dev[20'h12346] = 8'hCD;
    refm[20'h12345] = 8'hAB; refm[20'h12346] = 8'hCD;

    txn(0, 1'b0, 1'b0, 20'h12345, 16'h0000, 1);
    chk("word_read_12345", dato_v[0], 16'hCDAB);

    txn(0, 1'b1, 1'b1, 20'h00010, 16'hFF5A, 1);
    chk("byte_wr_lo", dev_rd(20'h00010), 8'h5A);
    chk("byte_wr_hi_untouched", dev_rd(20'h00011), seed_b(20'h00011));
    txn(0, 1'b0, 1'b1, 20'h00010, 16'h0000, 1);
    chk("byte_read_10", dato_v[0], 16'h005A);

    txn(0, 1'b1, 1'b0, 20'hFFFFF, 16'hBEEF, 1);
    chk("wrap_lo", dev_rd(20'hFFFFF), 8'hEF);
    chk("wrap_hi", dev_rd(20'h00000), 8'hBE);

    b2b(20'h12345, 20'hFFFFF);

    // stb released during the HI strobe
    txn(0, 1'b0, 1'b0, 20'h00010, 16'h0000, wait_of(0) + 4);

    // Reset during the HI strobe of a word write
    @(negedge clk);
    adr = 20'h80010; dat = 16'h1234; we = 1'b1; byt = 1'b0; stb_v[0] = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= wait_of(0) + 4; n++) begin
      @(negedge clk);
      if (n == 1) stb_v[0] = 1'b0;
    end
    chk("hi_strobe_before_rst", we_n[0], 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_controls", {ce_n[0], oe_n[0], we_n[0]}, 3'b111);
    chk("rst_no_ack", ack_v[0], 1'b0);
    chk("rst_adr", madr[0], 20'h00000);
    rst_n = 1'b1;
    for (int g = 0; g < 3; g++) last_rd[g] = '0;
    nack = 0;
    repeat (12) begin
      @(negedge clk);
      if (ack_v[0]) nack++;
    end
    chk("rst_ack_never", nack, 0);
    chk("rst_lo_written", dev_rd(20'h80010), 8'h34);

    txn(0, 1'b0, 1'b0, 20'h12345, 16'h0000, 1);

    for (int i = 0; i < 40; i++) begin
      ra = 20'h00100 + 20'($urandom_range(0, 31));
      txn(0, 1'($urandom), 1'($urandom), ra, 16'($urandom), $urandom_range(1, 3));
    end

    txn(1, 1'b0, 1'b0, 20'($urandom), 16'h0000, 1);
    txn(1, 1'b0, 1'b1, 20'($urandom), 16'h0000, 1);
    txn(2, 1'b0, 1'b0, 20'($urandom), 16'h0000, 1);
    txn(2, 1'b0, 1'b1, 20'hFFFFF, 16'h0000, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
